// File: rtl/async_handshake_tx_pkg.sv
// Shared types and default sizing for the four-phase bundled-data initiator.
package async_handshake_tx_pkg;

   localparam int unsigned DefDw         = 8;
   localparam int unsigned DefSyncStages = 2;
   localparam int unsigned DefTimeout    = 255;

   typedef enum logic [1:0] {
      StIdle,
      StSetup,
      StReqHi,
      StReqLo
   } hs_state_e;

endpackage

// File: rtl/async_handshake_tx_if.sv
// Local word interface plus the bundled-data request/acknowledge pair.
interface async_handshake_tx_if
   import async_handshake_tx_pkg::*;
#(
   parameter int unsigned DW = DefDw
) ();

   logic          tx_valid;
   logic [DW-1:0] tx_data;
   logic          tx_ready;
   logic [DW-1:0] data_out;
   logic          req_out;
   logic          ack_in;
   logic          busy;
   logic          timeout_err;

   // Seen from the initiator block.
   modport slave (
      input  tx_valid,
      input  tx_data,
      input  ack_in,
      output tx_ready,
      output data_out,
      output req_out,
      output busy,
      output timeout_err
   );

   // Seen from the local producer and the remote receiver.
   modport master (
      output tx_valid,
      output tx_data,
      output ack_in,
      input  tx_ready,
      input  data_out,
      input  req_out,
      input  busy,
      input  timeout_err
   );

endinterface

// File: rtl/async_handshake_tx_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit, cleared by synchronous reset.
module async_handshake_tx_sync_chain
   import async_handshake_tx_pkg::*;
#(
   parameter int unsigned STAGES = DefSyncStages
) (
   input  logic clk,
   input  logic rst,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[STAGES-2:0], d_i};
      end
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/async_handshake_tx.sv
// Four-phase return-to-zero initiator: latches a local word, drives req, and
// tracks the synchronized acknowledge with a per-phase timeout.
module async_handshake_tx
   import async_handshake_tx_pkg::*;
#(
   parameter int unsigned DW          = DefDw,
   parameter int unsigned SYNC_STAGES = DefSyncStages,
   parameter int unsigned TIMEOUT     = DefTimeout
) (
   input logic                 clk,
   input logic                 rst,
   async_handshake_tx_if.slave bus_io
);

   localparam int unsigned     TO_W    = $clog2(TIMEOUT + 1);
   localparam logic [TO_W-1:0] CntLast = TO_W'(TIMEOUT - 1);
   localparam logic [TO_W-1:0] CntMax  = TO_W'(TIMEOUT);

   hs_state_e       state_q, state_d;
   logic [DW-1:0]   data_q, data_d;
   logic            req_q, req_d;
   logic [TO_W-1:0] cnt_q, cnt_d;
   logic            err_q, err_d;
   logic            ack_s;
   logic            tx_ready;

   async_handshake_tx_sync_chain #(
      .STAGES (SYNC_STAGES)
   ) u_ack_sync (
      .clk (clk),
      .rst (rst),
      .d_i (bus_io.ack_in),
      .q_o (ack_s)
   );

   // Hold off new words while the receiver still shows the previous ack.
   assign tx_ready = (state_q == StIdle) && !ack_s;

   always_comb begin
      state_d = state_q;
      data_d  = data_q;
      req_d   = req_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;

      if ((state_q == StReqHi || state_q == StReqLo) && cnt_q != CntMax) begin
         cnt_d = cnt_q + TO_W'(1);
      end

      unique case (state_q)
         StIdle: begin
            if (bus_io.tx_valid && tx_ready) begin
               data_d  = bus_io.tx_data;
               state_d = StSetup;
            end
         end
         StSetup: begin
            req_d   = 1'b1;
            cnt_d   = '0;
            state_d = StReqHi;
         end
         StReqHi: begin
            // Ack takes priority over a terminal count in the same cycle.
            if (ack_s) begin
               req_d   = 1'b0;
               cnt_d   = '0;
               state_d = StReqLo;
            end else if (cnt_q == CntLast) begin
               req_d   = 1'b0;
               err_d   = 1'b1;
               cnt_d   = '0;
               state_d = StReqLo;
            end
         end
         StReqLo: begin
            if (!ack_s) begin
               state_d = StIdle;
            end else if (cnt_q == CntLast) begin
               err_d   = 1'b1;
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         data_q  <= '0;
         req_q   <= 1'b0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         data_q  <= data_d;
         req_q   <= req_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus_io.tx_ready    = tx_ready;
   assign bus_io.data_out    = data_q;
   assign bus_io.req_out     = req_q;
   assign bus_io.busy        = (state_q != StIdle);
   assign bus_io.timeout_err = err_q;

endmodule

// File: tb/tb_async_handshake_tx.sv
// Scenario bench for async_handshake_tx: words are queued on accept and popped when req rises.
module tb_async_handshake_tx;

   localparam int unsigned DW   = 8;
   localparam int unsigned SYNC = 2;
   localparam int unsigned TO   = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;

   async_handshake_tx_if #(.DW(DW)) h ();

   async_handshake_tx #(
      .DW          (DW),
      .SYNC_STAGES (SYNC),
      .TIMEOUT     (TO)
   ) dut (
      .clk    (clk),
      .rst    (rst),
      .bus_io (h)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;
   int to_pulses = 0;
   int req_rises = 0;
   int ack_low_cnt = 0;
   logic [DW-1:0] sb[$];

   // Scoreboard pop on each req rise; data must hold while req is high.
   initial begin : monitor
      logic          prev_req;
      logic [DW-1:0] prev_data;
      logic [DW-1:0] exp;
      prev_req  = 1'b0;
      prev_data = '0;
      forever begin
         @(negedge clk);
         if (!rst) begin
            if (h.req_out === 1'b1 && prev_req !== 1'b1) begin
               req_rises++;
               total++;
               if (sb.size() == 0) begin
                  bad++;
                  $display("FAIL sb_underflow: req rose with data_out=%h, no word queued", h.data_out);
               end else begin
                  exp = sb.pop_front();
                  if (h.data_out !== exp) begin
                     bad++;
                     $display("FAIL sb_data: data_out=%h expected=%h", h.data_out, exp);
                  end
               end
            end else if (h.req_out === 1'b1 && prev_req === 1'b1) begin
               total++;
               if (h.data_out !== prev_data) begin
                  bad++;
                  $display("FAIL data_stable: data_out=%h expected=%h", h.data_out, prev_data);
               end
            end
            if (h.timeout_err === 1'b1) to_pulses++;
         end
         prev_req  = h.req_out;
         prev_data = h.data_out;
      end
   end

   initial begin : ack_low_tracker
      forever begin
         @(posedge clk);
         if (h.ack_in === 1'b1) ack_low_cnt = 0;
         else ack_low_cnt++;
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_req(input logic lvl, output int n, output bit ok);
      n = 0;
      while (h.req_out !== lvl && n < 200) begin
         tick();
         n++;
      end
      ok = (h.req_out === lvl);
   endtask

   task automatic wait_ready(output int n);
      n = 0;
      while (h.tx_ready !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
   endtask

   // Receiver side of one four-phase handshake with fixed response delays.
   task automatic rx_handshake(input int hi_dly, input int lo_dly);
      int n;
      bit ok;
      wait_req(1'b1, n, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rx_req_rise: req_out=%b expected=1", h.req_out); end
      repeat (hi_dly) tick();
      h.ack_in = 1'b1;
      wait_req(1'b0, n, ok);
      total++;
      if (!ok) begin bad++; $display("FAIL rx_req_fall: req_out=%b expected=0", h.req_out); end
      repeat (lo_dly) tick();
      h.ack_in = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      h.tx_valid = 1'b0;
      h.tx_data  = '0;
      h.ack_in   = 1'b0;
      tick();
      tick();
      total += 4;
      if (h.req_out !== 1'b0) begin bad++; $display("FAIL rst_req: got %b want 0", h.req_out); end
      if (h.data_out !== '0) begin bad++; $display("FAIL rst_data: got %h want 00", h.data_out); end
      if (h.busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", h.busy); end
      if (h.timeout_err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", h.timeout_err); end
      rst = 1'b0;
      tick();
      total++;
      if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", h.tx_ready); end
   endtask

   task automatic test_normal();
      int p0, n;
      bit ok;
      p0 = to_pulses;
      h.tx_data  = 8'hA5;
      h.tx_valid = 1'b1;
      total++;
      if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL t1_ready: got %b want 1", h.tx_ready); end
      sb.push_back(8'hA5);
      tick();
      h.tx_valid = 1'b0;
      total += 4;
      if (h.data_out !== 8'hA5) begin bad++; $display("FAIL t1_setup_data: got %h want a5", h.data_out); end
      if (h.req_out !== 1'b0) begin bad++; $display("FAIL t1_setup_req: got %b want 0", h.req_out); end
      if (h.busy !== 1'b1) begin bad++; $display("FAIL t1_busy: got %b want 1", h.busy); end
      if (h.tx_ready !== 1'b0) begin bad++; $display("FAIL t1_ready_low: got %b want 0", h.tx_ready); end
      tick();
      total++;
      if (h.req_out !== 1'b1) begin bad++; $display("FAIL t1_req_rise: got %b want 1", h.req_out); end
      repeat (3) tick();
      h.ack_in = 1'b1;
      wait_req(1'b0, n, ok);
      total++;
      if (!ok || n != SYNC + 1) begin
         bad++;
         $display("FAIL t1_req_fall_lat: got %0d cycles want %0d", n, SYNC + 1);
      end
      repeat (3) tick();
      h.ack_in = 1'b0;
      wait_ready(n);
      total += 3;
      if (n != SYNC + 1) begin bad++; $display("FAIL t1_ready_lat: got %0d want %0d", n, SYNC + 1); end
      if (h.busy !== 1'b0) begin bad++; $display("FAIL t1_idle: busy=%b want 0", h.busy); end
      if (to_pulses != p0) begin bad++; $display("FAIL t1_no_err: pulses=%0d want 0", to_pulses - p0); end
   endtask

   task automatic test_back_to_back();
      int r0;
      logic [DW-1:0] words[2];
      words[0] = 8'h01;
      words[1] = 8'h02;
      r0 = req_rises;
      fork
         begin
            int n;
            h.tx_valid = 1'b1;
            for (int i = 0; i < 2; i++) begin
               h.tx_data = words[i];
               wait_ready(n);
               total++;
               if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL t2_ready_%0d: got %b want 1", i, h.tx_ready); end
               if (i == 1) begin
                  total++;
                  if (ack_low_cnt < SYNC + 1) begin
                     bad++;
                     $display("FAIL t2_early_accept: ack low %0d cycles want >=%0d", ack_low_cnt, SYNC + 1);
                  end
               end
               sb.push_back(words[i]);
               tick();
            end
            h.tx_valid = 1'b0;
         end
         begin
            rx_handshake(3, 3);
            rx_handshake(3, 3);
         end
      join
      total += 2;
      if (req_rises - r0 != 2) begin bad++; $display("FAIL t2_cycles: got %0d want 2", req_rises - r0); end
      if (sb.size() != 0) begin bad++; $display("FAIL t2_sb_left: got %0d want 0", sb.size()); end
      begin
         int n;
         wait_ready(n);
      end
   endtask

   task automatic test_dead_receiver();
      int p0, n;
      bit ok;
      p0 = to_pulses;
      h.ack_in   = 1'b0;
      h.tx_data  = 8'h3C;
      h.tx_valid = 1'b1;
      sb.push_back(8'h3C);
      tick();
      h.tx_valid = 1'b0;
      wait_req(1'b1, n, ok);
      n = 1;
      while (h.req_out === 1'b1 && n < 100) begin
         tick();
         if (h.req_out === 1'b1) n++;
      end
      total += 2;
      if (!ok || n != TO) begin bad++; $display("FAIL t3_req_width: got %0d want %0d", n, TO); end
      if (h.timeout_err !== 1'b1) begin bad++; $display("FAIL t3_err: got %b want 1", h.timeout_err); end
      tick();
      total += 4;
      if (h.timeout_err !== 1'b0) begin bad++; $display("FAIL t3_err_pulse: got %b want 0", h.timeout_err); end
      if (h.busy !== 1'b0) begin bad++; $display("FAIL t3_idle: busy=%b want 0", h.busy); end
      if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL t3_ready: got %b want 1", h.tx_ready); end
      if (to_pulses - p0 != 1) begin bad++; $display("FAIL t3_pulses: got %0d want 1", to_pulses - p0); end
   endtask

   task automatic test_stuck_ack();
      int p0, n;
      bit ok;
      p0 = to_pulses;
      h.tx_data  = 8'h5A;
      h.tx_valid = 1'b1;
      sb.push_back(8'h5A);
      tick();
      h.tx_valid = 1'b0;
      wait_req(1'b1, n, ok);
      repeat (3) tick();
      h.ack_in = 1'b1;
      wait_req(1'b0, n, ok);
      n = 0;
      while (h.timeout_err !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      total += 3;
      if (!ok || n != TO) begin bad++; $display("FAIL t4_lo_timeout: got %0d want %0d", n, TO); end
      if (h.busy !== 1'b0) begin bad++; $display("FAIL t4_idle: busy=%b want 0", h.busy); end
      if (h.tx_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_held: got %b want 0", h.tx_ready); end
      repeat (5) tick();
      total += 2;
      if (h.tx_ready !== 1'b0) begin bad++; $display("FAIL t4_ready_still: got %b want 0", h.tx_ready); end
      if (h.timeout_err !== 1'b0) begin bad++; $display("FAIL t4_err_pulse: got %b want 0", h.timeout_err); end
      h.ack_in = 1'b0;
      wait_ready(n);
      total += 2;
      if (n != SYNC) begin bad++; $display("FAIL t4_release_lat: got %0d want %0d", n, SYNC); end
      if (to_pulses - p0 != 1) begin bad++; $display("FAIL t4_pulses: got %0d want 1", to_pulses - p0); end
   endtask

   task automatic test_reset_mid_op();
      int n;
      bit ok;
      h.tx_data  = 8'h77;
      h.tx_valid = 1'b1;
      sb.push_back(8'h77);
      tick();
      h.tx_valid = 1'b0;
      wait_req(1'b1, n, ok);
      repeat (2) tick();
      rst = 1'b1;
      tick();
      total += 4;
      if (h.req_out !== 1'b0) begin bad++; $display("FAIL t5_req: got %b want 0", h.req_out); end
      if (h.data_out !== '0) begin bad++; $display("FAIL t5_data: got %h want 00", h.data_out); end
      if (h.busy !== 1'b0) begin bad++; $display("FAIL t5_busy: got %b want 0", h.busy); end
      if (h.timeout_err !== 1'b0) begin bad++; $display("FAIL t5_err: got %b want 0", h.timeout_err); end
      rst = 1'b0;
      h.tx_data  = 8'h88;
      h.tx_valid = 1'b1;
      total++;
      if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL t5_ready: got %b want 1", h.tx_ready); end
      sb.push_back(8'h88);
      tick();
      h.tx_valid = 1'b0;
      rx_handshake(2, 2);
      wait_ready(n);
      total += 2;
      if (h.busy !== 1'b0) begin bad++; $display("FAIL t5_done: busy=%b want 0", h.busy); end
      if (sb.size() != 0) begin bad++; $display("FAIL t5_sb_left: got %0d want 0", sb.size()); end
   endtask

   task automatic test_race();
      int p0, n;
      bit ok;
      p0 = to_pulses;
      h.tx_data  = 8'h99;
      h.tx_valid = 1'b1;
      sb.push_back(8'h99);
      tick();
      h.tx_valid = 1'b0;
      wait_req(1'b1, n, ok);
      // ack_s arrives in the cycle where the counter sits at its last value.
      repeat (TO - SYNC - 1) tick();
      h.ack_in = 1'b1;
      wait_req(1'b0, n, ok);
      total += 3;
      if (!ok || n != SYNC + 1) begin bad++; $display("FAIL t6_fall: got %0d want %0d", n, SYNC + 1); end
      if (h.timeout_err !== 1'b0) begin bad++; $display("FAIL t6_err: got %b want 0", h.timeout_err); end
      if (h.busy !== 1'b1) begin bad++; $display("FAIL t6_req_lo: busy=%b want 1", h.busy); end
      repeat (2) tick();
      h.ack_in = 1'b0;
      wait_ready(n);
      total += 2;
      if (to_pulses != p0) begin bad++; $display("FAIL t6_pulses: got %0d want 0", to_pulses - p0); end
      if (h.tx_ready !== 1'b1) begin bad++; $display("FAIL t6_ready: got %b want 1", h.tx_ready); end
   endtask

   initial begin
      test_reset();
      test_normal();
      test_back_to_back();
      test_dead_receiver();
      test_stuck_ack();
      test_reset_mid_op();
      test_race();
      repeat (3) tick();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
